char_mem_arbiter: RTL and testbench
===================================

Name: char_mem_arbiter

Overview:
- Shares the single-port, synchronous-read character memory between two requesters: the text-mode display fetch and a CPU load/store port.
- Display fetches are fixed-time slots derived from the VGA pixel/line counters. The CPU gets every cycle the display does not use.
- Sits between the VGA timing generator, the CPU bus and the character RAM. Its display output feeds the glyph/font lookup stage.

Parameters:
- ADDR_W, 15, memory address width.
- DATA_W, 16, memory word width.
- CHAR_BASE, 15'h5FF, base address of the character buffer, added to the cell index.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- pixel_counter  in  10  horizontal pixel position from the VGA timing generator.
- line_counter  in  10  vertical line position from the VGA timing generator.
- video_on  in  1  high in the active display region.
- disp_valid  out  1  one-cycle pulse; disp_data holds the fetched character word.
- disp_data  out  DATA_W  last fetched character word; held between pulses.
- cpu_req  in  1  CPU request; held stable until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  combinational accept; the request is consumed in any cycle where cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_rdata  out  DATA_W  read data; held between pulses.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.

Behaviour:
- Display slot (cycle T): video_on && pixel_counter[2:0]==3'd0.
- Display address: {2'd0, line_counter[8:3], pixel_counter[9:3]} + CHAR_BASE, truncated to ADDR_W. Sum wraps mod 2^15; no saturation.
- Arbitration each cycle, at most one memory op issued:
  - Display slot wins.
  - cpu_ready = !slot, so the CPU is blocked only in slot cycles: at most 1 stall cycle in 8 during active video, 0 in blanking.
- Issue: the chosen op is registered into mem_addr/mem_we/mem_wdata at the edge ending cycle T. It is presented during T+1.
- Idle cycles: mem_we=0 and mem_addr holds its last value.
- Display write suppression: mem_we=0 for display ops.
- Tag pipeline: a 2-stage owner tag {NONE, DISP, CPU_RD} tracks each read issued.
  - Read data returns during T+2 and is captured at the end of T+2.
  - disp_valid or cpu_rvalid pulses during T+3, i.e. 3 cycles after the slot or accept cycle.
  - Captured data is held until the next capture for the same owner.
- CPU writes: memory write occurs in T+1. No rvalid is generated.
- Ordering: back-to-back CPU accepts are allowed every non-slot cycle. A read following a write to the same address returns the new data (program order kept).
- Reset:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Tags cleared to NONE.
  - disp_valid=0, cpu_rvalid=0, disp_data=0, cpu_rdata=0.
  - In-flight reads are dropped: no valid pulse appears after reset deasserts for an op issued before reset.
  - cpu_ready=0 while reset is high.
- video_on falling mid-line: no further slots. Already-issued display reads still complete and pulse.
- No internal counters beyond the tag pipe. Slot timing depends only on the counter inputs.

Decomposition:
- Shared package/include:
  - CHAR_BASE.
  - Owner tag encodings TAG_NONE=2'd0, TAG_DISP=2'd1, TAG_CPU=2'd2.
  - Slot phase constant SLOT_PHASE=3'd0.
- One natural sub-module: mem_tag_pipe. It is a 2-deep owner-tag shift register with synchronous reset, and it performs the valid-pulse decode.

Test Plan:
- Display only: video_on=1, line_counter=16, pixel_counter=24 at T → mem_addr=0x05FF+(2<<7)+3=0x0702 during T+1; memory returns 0x0041 → disp_valid pulse at T+3, disp_data=0x0041.
- CPU blocked by slot: cpu_req read addr 0x0100 held across a slot cycle → cpu_ready=0 in the slot cycle, 1 in the next cycle (T'); cpu_rvalid at T'+3 with the memory word.
- Blanking throughput: video_on=0, 8 consecutive CPU writes 0x0200..0x0207 → cpu_ready=1 every cycle; 8 consecutive mem_we pulses; no disp_valid.
- Write-then-read: write 0xBEEF to 0x0300, next cycle read 0x0300 → cpu_rdata=0xBEEF, rvalid 3 cycles after the read accept.
- Wrap: line_counter=511, pixel_counter=1016, CHAR_BASE=0x7FFF → mem_addr=(0x7FFF+0x1FFF) mod 2^15=0x1FFE.
- Reset mid-flight: assert reset the cycle after a display slot issue → disp_valid stays 0; all outputs at reset values; normal slots resume after deassertion.

Source files
------------

// File: rtl/char_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// char_mem_arbiter_pkg
// Shared constants and types for the character-memory arbiter slice.
//   CHAR_BASE   : default base address of the character buffer.
//   SLOT_PHASE  : pixel_counter[2:0] value that marks a display fetch slot.
//   owner_tag_t : owner of a memory read travelling down the tag pipe.
//   cell_index  : text cell index {row, column} from the VGA counters.
// ---------------------------------------------------------------------------
package char_mem_arbiter_pkg;

  localparam logic [14:0] CHAR_BASE  = 15'h5FF;
  localparam logic [2:0]  SLOT_PHASE = 3'd0;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } owner_tag_t;

  // One cell is 8x8 pixels: row = line[8:3] (64 rows), column = pixel[9:3]
  // (128 columns), packed row-major with 128 cells per row.
  function automatic logic [12:0] cell_index(input logic [9:0] pixel,
                                             input logic [9:0] line);
    return {line[8:3], pixel[9:3]};
  endfunction

endpackage

// File: rtl/char_mem_arbiter_mem_tag_pipe.sv
// ---------------------------------------------------------------------------
// mem_tag_pipe
// Two-deep owner-tag shift register that follows each issued memory op.
// Stage 0 lines up with the cycle the op is presented to the RAM, stage 1
// with the cycle the RAM returns read data. The stage-1 decode tells the
// parent which owner's data register captures mem_rdata this cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (clears all tags).
//   issue_tag     : owner of the op being registered this cycle.
//   disp_capture  : read data returning this cycle belongs to the display.
//   cpu_capture   : read data returning this cycle belongs to the CPU.
// ---------------------------------------------------------------------------
module mem_tag_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] issue_tag,
  output logic       disp_capture,
  output logic       cpu_capture
);
  import char_mem_arbiter_pkg::*;

  owner_tag_t tag_q0;
  owner_tag_t tag_q1;

  // NOTE: state registers use non-blocking assignments so both stages shift
  // on the same edge; blocking here would collapse the pipe into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q0 <= TAG_NONE;
      tag_q1 <= TAG_NONE;
    end else begin
      tag_q0 <= owner_tag_t'(issue_tag);
      tag_q1 <= tag_q0;
    end
  end

  assign disp_capture = (tag_q1 == TAG_DISP);
  assign cpu_capture  = (tag_q1 == TAG_CPU);

endmodule

// File: rtl/char_mem_arbiter.sv
// ---------------------------------------------------------------------------
// char_mem_arbiter
// Shares a single-port, synchronous-read character RAM between the text-mode
// display fetch and a CPU load/store port. The display owns one fixed slot
// every 8 pixels of active video; the CPU gets every other cycle.
// Ports:
//   clk, reset                 : pixel clock, synchronous active-high reset.
//   pixel_counter, line_counter: VGA timing position.
//   video_on                   : active display region.
//   disp_valid / disp_data     : fetched character word (pulse / held data).
//   cpu_req/we/addr/wdata      : CPU request, held until accepted.
//   cpu_ready                  : combinational accept (not a slot, not reset).
//   cpu_rvalid / cpu_rdata     : CPU read return (pulse / held data).
//   mem_addr/we/wdata          : registered RAM controls.
//   mem_rdata                  : RAM data, one cycle after mem_addr.
// Latency: slot/accept in cycle T, op on the RAM in T+1, data back in T+2,
// valid pulse in T+3.
// ---------------------------------------------------------------------------
module char_mem_arbiter #(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] CHAR_BASE = char_mem_arbiter_pkg::CHAR_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_counter,
  input  logic [9:0]        line_counter,
  input  logic              video_on,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import char_mem_arbiter_pkg::*;

  logic              slot;
  logic              cpu_accept;
  logic [ADDR_W-1:0] disp_addr;
  owner_tag_t        issue_tag;
  logic              disp_capture;
  logic              cpu_capture;

  assign slot       = video_on && (pixel_counter[2:0] == SLOT_PHASE);
  assign cpu_ready  = !reset && !slot;
  assign cpu_accept = cpu_req && cpu_ready;

  // Sum wraps modulo 2^ADDR_W by construction of the result width.
  assign disp_addr = ADDR_W'(cell_index(pixel_counter, line_counter)) + CHAR_BASE;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    issue_tag = TAG_NONE;
    if (slot)
      issue_tag = TAG_DISP;
    else if (cpu_accept && !cpu_we)
      issue_tag = TAG_CPU;
  end

  // Display ops never write; idle cycles keep the last address on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (slot) begin
        mem_addr <= disp_addr;
      end else if (cpu_accept) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  mem_tag_pipe u_tag_pipe (
    .clk          (clk),
    .reset        (reset),
    .issue_tag    (issue_tag),
    .disp_capture (disp_capture),
    .cpu_capture  (cpu_capture)
  );

  // Each owner's data register only updates on its own capture, so it holds
  // between pulses even while the other owner is reading.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      disp_valid <= disp_capture;
      cpu_rvalid <= cpu_capture;
      if (disp_capture) disp_data <= mem_rdata;
      if (cpu_capture)  cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_char_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_char_mem_arbiter
// Directed stimulus with a scoreboard: each issued read pushes its expected
// word and pulse cycle into a per-owner queue; a negedge monitor pops and
// compares whenever disp_valid or cpu_rvalid pulses. A behavioural RAM model
// sits on the mem_* bus. A second instance with CHAR_BASE=0x7FFF covers the
// address wrap.
// ---------------------------------------------------------------------------
module tb_char_mem_arbiter;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_counter;
  logic [9:0]  line_counter;
  logic        video_on;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        w_disp_valid;
  logic [15:0] w_disp_data;
  logic        w_cpu_ready;
  logic        w_cpu_rvalid;
  logic [15:0] w_cpu_rdata;
  logic [14:0] w_mem_addr;
  logic        w_mem_we;
  logic [15:0] w_mem_wdata;

  logic [15:0] mem [0:32767];

  exp_t disp_q[$];
  exp_t cpu_q[$];
  exp_t de;
  exp_t ce;

  int n_tests     = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int disp_pulses = 0;
  int pulses_mark = 0;

  always #5 clk = ~clk;

  char_mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_counter (pixel_counter),
    .line_counter  (line_counter),
    .video_on      (video_on),
    .disp_valid    (disp_valid),
    .disp_data     (disp_data),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  char_mem_arbiter #(.CHAR_BASE(15'h7FFF)) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .pixel_counter (pixel_counter),
    .line_counter  (line_counter),
    .video_on      (video_on),
    .disp_valid    (w_disp_valid),
    .disp_data     (w_disp_data),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (w_cpu_ready),
    .cpu_rvalid    (w_cpu_rvalid),
    .cpu_rdata     (w_cpu_rdata),
    .mem_addr      (w_mem_addr),
    .mem_we        (w_mem_we),
    .mem_wdata     (w_mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Behavioural single-port RAM with synchronous read.
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      disp_pulses++;
      if (disp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL disp_unexpected: pulse with data 0x%0h at cycle %0d, none queued",
                 disp_data, cyc);
      end else begin
        de = disp_q.pop_front();
        check("disp_data", disp_data, de.data);
        check("disp_cycle", cyc, de.cyc);
      end
    end
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cpu_unexpected: rvalid with data 0x%0h at cycle %0d, none queued",
                 cpu_rdata, cyc);
      end else begin
        ce = cpu_q.pop_front();
        check("cpu_rdata", cpu_rdata, ce.data);
        check("cpu_cycle", cyc, ce.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] <= 16'h0000;
    mem[15'h0702] <= 16'h0041;
    mem[15'h0600] <= 16'h0042;
    mem[15'h0100] <= 16'h1234;
    mem[15'h25FE] <= 16'h0055;
    mem[15'h05FF] <= 16'h0077;
    mem[15'h0681] <= 16'h0099;

    reset         = 1'b1;
    video_on      = 1'b0;
    pixel_counter = 10'd0;
    line_counter  = 10'd0;
    cpu_req       = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 15'h0000;
    cpu_wdata     = 16'h0000;

    // Reset state, with a pending CPU request that must not be accepted.
    repeat (3) step();
    check("rst_ready",      cpu_ready,  0);
    check("rst_mem_we",     mem_we,     0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data",  disp_data,  0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata",  cpu_rdata,  0);
    reset   = 1'b0;
    cpu_req = 1'b0;
    step();

    // Display only: line 16, pixel 24 -> 0x05FF + (2<<7) + 3 = 0x0702.
    video_on = 1'b1; line_counter = 10'd16; pixel_counter = 10'd24;
    #1 check("slot_ready", cpu_ready, 0);
    disp_q.push_back('{16'h0041, cyc + 3});
    step();
    video_on = 1'b0;
    check("disp_addr", mem_addr, 15'h0702);
    check("disp_we",   mem_we,   0);
    repeat (4) step();

    // CPU read held across a slot (line 0, pixel 8 -> 0x0600).
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    video_on = 1'b1; line_counter = 10'd0; pixel_counter = 10'd8;
    #1 check("blocked_ready", cpu_ready, 0);
    disp_q.push_back('{16'h0042, cyc + 3});
    step();
    pixel_counter = 10'd9;
    #1 check("unblocked_ready", cpu_ready, 1);
    check("slot2_addr", mem_addr, 15'h0600);
    cpu_q.push_back('{16'h1234, cyc + 3});
    step();
    cpu_req = 1'b0; video_on = 1'b0;
    check("cpu_rd_addr", mem_addr, 15'h0100);
    check("cpu_rd_we",   mem_we,   0);
    repeat (4) step();

    // Blanking throughput: 8 back-to-back writes, one per cycle.
    for (int i = 0; i < 8; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr  = 15'h0200 + 15'(i);
      cpu_wdata = 16'hA000 + 16'(i);
      #1 check("blank_ready", cpu_ready, 1);
      step();
      check("blank_we",    mem_we,    1);
      check("blank_addr",  mem_addr,  15'h0200 + 15'(i));
      check("blank_wdata", mem_wdata, 16'hA000 + 16'(i));
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    check("idle_we",   mem_we,   0);
    check("idle_addr", mem_addr, 15'h0207);

    // Write then read the same address, then read back a blanking write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 16'hBEEF;
    step();
    cpu_we = 1'b0;
    cpu_q.push_back('{16'hBEEF, cyc + 3});
    step();
    cpu_addr = 15'h0203;
    cpu_q.push_back('{16'hA003, cyc + 3});
    step();
    cpu_req = 1'b0;
    repeat (5) step();

    // Address wrap: cell index 0x1FFF; 0x7FFF base wraps to 0x1FFE.
    video_on = 1'b1; line_counter = 10'd511; pixel_counter = 10'd1016;
    disp_q.push_back('{16'h0055, cyc + 3});
    step();
    video_on = 1'b0;
    check("nowrap_addr", mem_addr,   15'h25FE);
    check("wrap_addr",   w_mem_addr, 15'h1FFE);
    repeat (5) step();

    // Reset the cycle after a display issue: the fetch must be dropped.
    video_on = 1'b1; line_counter = 10'd8; pixel_counter = 10'd16;
    step();
    video_on = 1'b0; reset = 1'b1;
    #1 check("rst_mid_ready", cpu_ready, 0);
    pulses_mark = disp_pulses;
    step();
    reset = 1'b0;
    check("rst2_mem_addr",   mem_addr,   0);
    check("rst2_mem_we",     mem_we,     0);
    check("rst2_mem_wdata",  mem_wdata,  0);
    check("rst2_disp_valid", disp_valid, 0);
    check("rst2_disp_data",  disp_data,  0);
    check("rst2_cpu_rvalid", cpu_rvalid, 0);
    check("rst2_cpu_rdata",  cpu_rdata,  0);
    repeat (5) step();
    check("rst_drop_pulses", disp_pulses - pulses_mark, 0);

    // Slots resume: line 0, pixel 0 -> 0x05FF.
    video_on = 1'b1; line_counter = 10'd0; pixel_counter = 10'd0;
    disp_q.push_back('{16'h0077, cyc + 3});
    step();
    video_on = 1'b0;
    check("resume_addr", mem_addr, 15'h05FF);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 20; i++) begin
      if (disp_q.size() == 0 && cpu_q.size() == 0) break;
      step();
    end
    step();
    check("disp_q_drained", disp_q.size(), 0);
    check("cpu_q_drained",  cpu_q.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
